// File: rtl/inv_port_arbiter.sv
// Round-robin arbiter sharing the inventory RAM's system port B, with atomic DEC/INC read-modify-write.
// Define INV_ARB_PRIO0_EN to give requester 0 fixed highest priority over the round-robin group.
module inv_port_arbiter #(
    parameter  int NUM_REQ    = 3,
    parameter  int DATA_WIDTH = 16,
    parameter  int ADDR_WIDTH = 8,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [2*NUM_REQ-1:0]           req_op,
    input  logic [ADDR_WIDTH*NUM_REQ-1:0]  req_addr,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             ack,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           rsp_err,
    output logic                           busy,
    output logic [IDX_W-1:0]               grant_idx,
    output logic [ADDR_WIDTH-1:0]          ram_addr,
    output logic [DATA_WIDTH-1:0]          ram_wdata,
    output logic                           ram_we,
    input  logic [DATA_WIDTH-1:0]          ram_q
);

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_DEC   = 2'b10,
        OP_INC   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_WRITEBACK,
        S_DONE
    } state_e;

    localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

    state_e                  r_state;
    op_e                     r_op;
    logic [IDX_W-1:0]        r_rr_ptr;

    logic                    w_any;
    logic [IDX_W-1:0]        w_grant;
    logic [IDX_W-1:0]        w_next_ptr;
    op_e                     w_op;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [NUM_REQ-1:0]      w_ack_onehot;
    logic [DATA_WIDTH-1:0]   w_dec;
    logic [DATA_WIDTH-1:0]   w_inc;

    // Two passes: requesters at or above the pointer first, then the wrapped-around ones.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_any   = 1'b0;
        w_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_any && req[i] && i >= int'(r_rr_ptr)) begin
                w_any   = 1'b1;
                w_grant = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_any && req[i] && i < int'(r_rr_ptr)) begin
                w_any   = 1'b1;
                w_grant = IDX_W'(i);
            end
        end
`ifdef INV_ARB_PRIO0_EN
        if (req[0]) begin
            w_any   = 1'b1;
            w_grant = '0;
        end
`endif
    end

    always_comb begin
        w_op    = OP_READ;
        w_addr  = '0;
        w_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == IDX_W'(i)) begin
                w_op    = op_e'(req_op[2*i +: 2]);
                w_addr  = req_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
                w_wdata = req_wdata[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    assign w_next_ptr   = (w_grant == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant + IDX_W'(1);
    assign w_ack_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
    assign w_dec        = ram_q - DATA_WIDTH'(1);
    assign w_inc        = ram_q + DATA_WIDTH'(1);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= OP_READ;
            r_rr_ptr  <= '0;
            ack       <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            grant_idx <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    ack <= '0;
                    if (w_any) begin
                        grant_idx <= w_grant;
                        r_op      <= w_op;
                        ram_addr  <= w_addr;
                        rsp_err   <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= S_ISSUE;
                        if (w_op == OP_WRITE) begin
                            ram_we    <= 1'b1;
                            ram_wdata <= w_wdata;
                            rsp_data  <= w_wdata;
                        end
`ifdef INV_ARB_PRIO0_EN
                        if (!req[0]) r_rr_ptr <= w_next_ptr;
`else
                        r_rr_ptr <= w_next_ptr;
`endif
                    end
                end
                S_ISSUE: begin
                    ram_we <= 1'b0;
                    if (r_op == OP_WRITE) begin
                        ack     <= w_ack_onehot;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    case (r_op)
                        OP_DEC: begin
                            if (ram_q == '0) begin
                                rsp_err  <= 1'b1;
                                rsp_data <= '0;
                                ack      <= w_ack_onehot;
                                r_state  <= S_DONE;
                            end else begin
                                ram_wdata <= w_dec;
                                ram_we    <= 1'b1;
                                rsp_data  <= w_dec;
                                r_state   <= S_WRITEBACK;
                            end
                        end
                        OP_INC: begin
                            if (ram_q == ALL_ONES) begin
                                rsp_err  <= 1'b1;
                                rsp_data <= ram_q;
                                ack      <= w_ack_onehot;
                                r_state  <= S_DONE;
                            end else begin
                                ram_wdata <= w_inc;
                                ram_we    <= 1'b1;
                                rsp_data  <= w_inc;
                                r_state   <= S_WRITEBACK;
                            end
                        end
                        default: begin
                            rsp_data <= ram_q;
                            ack      <= w_ack_onehot;
                            r_state  <= S_DONE;
                        end
                    endcase
                end
                S_WRITEBACK: begin
                    ram_we  <= 1'b0;
                    ack     <= w_ack_onehot;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    ack     <= '0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    ack     <= '0;
                    busy    <= 1'b0;
                    ram_we  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_port_arbiter.sv
// Self-checking bench for inv_port_arbiter: vector table, round-robin order, atomic DEC race, reset abort.
// Expected grant order follows INV_ARB_PRIO0_EN when the bench is built with it.
module tb_inv_port_arbiter;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int AW = 8;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_DEC   = 2'b10;
    localparam logic [1:0] OP_INC   = 2'b11;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [2*N-1:0]  req_op = '0;
    logic [AW*N-1:0] req_addr = '0;
    logic [DW*N-1:0] req_wdata = '0;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            busy;
    logic [1:0]      grant_idx;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata;
    logic            ram_we;
    logic [DW-1:0]   ram_q;

    inv_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .ack(ack), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .grant_idx(grant_idx), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // Registered RAM model for port B, preloaded while `preload` is high.
    logic [DW-1:0] mem [0:255];
    logic          preload = 1'b1;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[8'h03] <= 16'h0002;
            mem[8'h08] <= 16'hFFFF;
            mem[8'h20] <= 16'h0A00;
            mem[8'h21] <= 16'h0A01;
            mem[8'h22] <= 16'h0A02;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_q <= mem[ram_addr];
    end

    typedef struct {
        int          idx;
        logic [1:0]  op;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr;
    } vec_t;

    typedef struct {
        logic [2:0]  ack;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_ack_seen = 0;
    int   n_ack_popped = 0;
    int   wr_count = 0;
    logic [7:0]  last_waddr = '0;
    logic [15:0] last_wdata = '0;

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            wr_count   = wr_count + 1;
            last_waddr = ram_addr;
            last_wdata = ram_wdata;
        end
        if (ack !== '0) n_ack_seen = n_ack_seen + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [15:0] d, input logic e);
        exp_t x;
        x.ack  = 3'b001 << idx;
        x.data = d;
        x.err  = e;
        sb.push_back(x);
    endtask

    task automatic sb_compare();
        exp_t x;
        n_ack_popped++;
        if (sb.size() == 0) begin
            check("unexpected_ack", 32'(ack), 32'h0);
        end else begin
            x = sb.pop_front();
            check("ack", 32'(ack), 32'(x.ack));
            check("rsp_data", 32'(rsp_data), 32'(x.data));
            check("rsp_err", 32'(rsp_err), 32'(x.err));
        end
    endtask

    task automatic drive(input int idx, input logic [1:0] op, input logic [7:0] addr,
                         input logic [15:0] wd);
        req_op[2*idx +: 2]     = op;
        req_addr[8*idx +: 8]   = addr;
        req_wdata[16*idx +: 16] = wd;
        req[idx]               = 1'b1;
    endtask

    task automatic do_txn(input vec_t v);
        int lat;
        int wr0;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        push_exp(v.idx, v.exp_data, v.exp_err);
        wr0 = wr_count;
        drive(v.idx, v.op, v.addr, v.wdata);
        while (!seen && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) check("busy_after_grant", 32'(busy), 32'h1);
            if (ack[v.idx] === 1'b1) seen = 1'b1;
        end
        check("latency", seen ? lat : 0, v.exp_lat);
        if (seen) sb_compare();
        req[v.idx] = 1'b0;
        check("ram_we_cycles", wr_count - wr0, v.exp_wr);
        if (v.exp_wr > 0) begin
            check("write_addr", 32'(last_waddr), 32'(v.addr));
            check("write_data", 32'(last_wdata), 32'(v.exp_data));
        end
        @(negedge clk);
    endtask

    // Requester agent: holds req until ack, drops it, re-requests after one idle cycle.
    task automatic agent(input int i, input int n, input logic [1:0] op, input logic [7:0] addr);
        for (int k = 0; k < n; k++) begin
            int t;
            t = 0;
            drive(i, op, addr, 16'h0000);
            do begin
                @(negedge clk);
                t++;
            end while (ack[i] !== 1'b1 && t < 60);
            check($sformatf("agent%0d_ack", i), 32'(ack[i]), 32'h1);
            if (ack[i] === 1'b1) sb_compare();
            req[i] = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},       32'(ack),       32'h0);
        check({tag, "_busy"},      32'(busy),      32'h0);
        check({tag, "_rsp_data"},  32'(rsp_data),  32'h0);
        check({tag, "_rsp_err"},   32'(rsp_err),   32'h0);
        check({tag, "_grant_idx"}, 32'(grant_idx), 32'h0);
        check({tag, "_ram_addr"},  32'(ram_addr),  32'h0);
        check({tag, "_ram_wdata"}, 32'(ram_wdata), 32'h0);
        check({tag, "_ram_we"},    32'(ram_we),    32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [13];
        vec_t v;
        int   order [6];
        int   cnt [3];
        int   wr0;

        tbl[0]  = '{1, OP_WRITE, 8'h05, 16'h0010, 16'h0010, 1'b0, 2, 1};
        tbl[1]  = '{0, OP_DEC,   8'h05, 16'h0000, 16'h000F, 1'b0, 4, 1};
        tbl[2]  = '{0, OP_DEC,   8'h07, 16'h0000, 16'h0000, 1'b1, 3, 0};
        tbl[3]  = '{2, OP_INC,   8'h08, 16'h0000, 16'hFFFF, 1'b1, 3, 0};
        tbl[4]  = '{2, OP_READ,  8'h05, 16'h0000, 16'h000F, 1'b0, 3, 0};
        tbl[5]  = '{1, OP_INC,   8'h05, 16'h0000, 16'h0010, 1'b0, 4, 1};
        tbl[6]  = '{0, OP_WRITE, 8'h07, 16'hFFFF, 16'hFFFF, 1'b0, 2, 1};
        tbl[7]  = '{1, OP_INC,   8'h07, 16'h0000, 16'hFFFF, 1'b1, 3, 0};
        tbl[8]  = '{2, OP_DEC,   8'h07, 16'h0000, 16'hFFFE, 1'b0, 4, 1};
        tbl[9]  = '{1, OP_READ,  8'h07, 16'h0000, 16'hFFFE, 1'b0, 3, 0};
        tbl[10] = '{0, OP_WRITE, 8'h09, 16'h1234, 16'h1234, 1'b0, 2, 1};
        tbl[11] = '{1, OP_INC,   8'h09, 16'h0000, 16'h1235, 1'b0, 4, 1};
        tbl[12] = '{2, OP_READ,  8'h08, 16'h0000, 16'hFFFF, 1'b0, 3, 0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst     = 1'b0;
        preload = 1'b0;
        @(negedge clk);

        foreach (tbl[k]) do_txn(tbl[k]);

        // All three requesting; the last table grant went to requester 2, so the pointer is at 0.
`ifdef INV_ARB_PRIO0_EN
        order = '{0, 1, 0, 2, 0, 1};
        cnt   = '{3, 2, 1};
`else
        order = '{0, 1, 2, 0, 1, 2};
        cnt   = '{2, 2, 2};
`endif
        foreach (order[k]) push_exp(order[k], 16'h0A00 | 16'(order[k]), 1'b0);
        fork
            agent(0, cnt[0], OP_READ, 8'h20);
            agent(1, cnt[1], OP_READ, 8'h21);
            agent(2, cnt[2], OP_READ, 8'h22);
        join

        // Reset lands while a DEC of 0x05 is in CAPTURE: nothing may be written or acked.
        wr0 = wr_count;
        drive(0, OP_DEC, 8'h05, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("busy_in_capture", 32'(busy), 32'h1);
        rst    = 1'b1;
        req[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("abort");
        rst = 1'b0;
        check("abort_no_write", wr_count - wr0, 0);
        @(negedge clk);
        v = '{2, OP_READ, 8'h05, 16'h0000, 16'h0010, 1'b0, 3, 0};
        do_txn(v);

        // Simultaneous DEC of the same count: both updates must land.
        push_exp(0, 16'h0001, 1'b0);
        push_exp(2, 16'h0000, 1'b0);
        fork
            agent(0, 1, OP_DEC, 8'h03);
            agent(2, 1, OP_DEC, 8'h03);
        join
        v = '{1, OP_READ, 8'h03, 16'h0000, 16'h0000, 1'b0, 3, 0};
        do_txn(v);
        v = '{0, OP_DEC, 8'h03, 16'h0000, 16'h0000, 1'b1, 3, 0};
        do_txn(v);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        check("ack_count", n_ack_seen, n_ack_popped);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_port_arbiter.md
Name: inv_port_arbiter

Overview:
- Shares the single system-side port of the inventory dual-port RAM among NUM_REQ requesters:
  - requester 0: vending dispense controller
  - requester 1: restock/service logic
  - requester 2: audit scanner
- Round-robin arbitration; one transaction in flight at a time.
- Provides atomic read-modify-write (decrement/increment of stock counts) so no two agents can race on the same count.
- Sits between the requesters and the RAM's port B, all in the system clock domain.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- DATA_WIDTH, 16, RAM word width
- ADDR_WIDTH, 8, RAM address width
- IDX_W, $clog2(NUM_REQ), grant index width (derived localparam)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  NUM_REQ  per-requester request, level, held until ack
- req_op  in  2*NUM_REQ  per-requester op: 00 READ, 01 WRITE, 10 DEC, 11 INC; slice i = [2i+1:2i]
- req_addr  in  ADDR_WIDTH*NUM_REQ  per-requester address
- req_wdata  in  DATA_WIDTH*NUM_REQ  per-requester write data (WRITE only)
- ack  out  NUM_REQ  one-hot, one-cycle completion pulse
- rsp_data  out  DATA_WIDTH  READ: word read; DEC/INC: new value (or unchanged value on error); WRITE: wdata
- rsp_err  out  1  valid with ack; DEC at 0 or INC at all-ones
- busy  out  1  high whenever state != IDLE
- grant_idx  out  IDX_W  index of the current/last granted requester
- ram_addr  out  ADDR_WIDTH  to RAM port B address
- ram_wdata  out  DATA_WIDTH  to RAM port B data
- ram_we  out  1  to RAM port B write enable
- ram_q  in  DATA_WIDTH  RAM port B read data; registered RAM, valid the cycle after the address is presented

Behaviour:
- Reset values: all outputs registered; 0 at reset (ack, rsp_data, rsp_err, busy, grant_idx, ram_addr, ram_wdata, ram_we); state = IDLE; rr_ptr = 0.
- IDLE
  - If any req bit is high, select the first set bit scanning from rr_ptr upward with wrap.
  - Latch grant_idx, op, addr and wdata; drive ram_addr.
  - For WRITE, also set ram_we=1 and ram_wdata=wdata.
  - Set rr_ptr = grant+1 mod NUM_REQ. Go to ISSUE.
- ISSUE: ram_we<=0. WRITE goes to DONE; otherwise go to CAPTURE.
- CAPTURE: ram_q is valid this cycle.
  - READ: rsp_data<=ram_q; go to DONE.
  - DEC with ram_q==0: rsp_err<=1, rsp_data<=0, no write; go to DONE.
  - INC with ram_q==all-ones: rsp_err<=1, rsp_data<=ram_q, no write; go to DONE.
  - Otherwise: ram_wdata=ram_q∓1 (DATA_WIDTH-bit, no wrap); ram_we<=1; rsp_data<=new value; go to WRITEBACK.
- WRITEBACK: ram_we<=0; go to DONE.
- DONE
  - ack[grant_idx]=1 for exactly this cycle; rsp_data and rsp_err are valid this cycle.
  - rsp_err is cleared on the next grant.
  - Go to IDLE.
- Latency from the IDLE cycle that sees req to the ack cycle:
  - WRITE: 2 cycles
  - READ: 3 cycles
  - DEC/INC error: 3 cycles
  - DEC/INC success: 4 cycles
- Handshake rules:
  - A requester must hold req, op, addr and wdata stable until it sees ack.
  - It must drop req in the cycle after ack; a still-high req in IDLE is treated as a new request.
  - The arbiter samples the request inputs only in IDLE.
- Arbitration:
  - Simultaneous requests are resolved by round-robin.
  - After a grant to i, requester i has the lowest priority.
  - With a single requester active, back-to-back grants go to it.
- Reset mid-operation:
  - Next state is IDLE, with no ack and rr_ptr=0.
  - If ram_we is high in the reset cycle (WRITE issue or WRITEBACK), that write completes at that edge; the RAM is never left half-updated.
- Out-of-range requester bits (NUM_REQ not a power of 2) are never granted.

Optional Feature:
- Macro: INV_ARB_PRIO0_EN.
- Defined: requester 0 has fixed highest priority. If req[0] is high in IDLE, it is granted regardless of rr_ptr, and rr_ptr is not updated. Remaining requesters rotate round-robin among themselves.
- Undefined: pure round-robin across all requesters as above.

Test Plan:
- Reset, then req[1]=1, op WRITE, addr 0x05, wdata 0x0010 -> ram_we high for one cycle with addr 0x05, data 0x0010; ack=3'b010 two cycles after grant; rsp_err=0.
- mem[0x05]=0x0010; req[0] DEC addr 0x05 -> single ram_we with ram_wdata 0x000F; ack[0] at cycle +4; rsp_data=0x000F.
- mem[0x07]=0x0000; DEC addr 0x07 -> no ram_we; ack at +3; rsp_err=1; rsp_data=0x0000. mem[0x08]=0xFFFF; INC -> rsp_err=1, no write.
- req=3'b111 held; each requester drops req after its ack and re-requests 1 cycle later -> grant order 0,1,2,0,1,2. With INV_ARB_PRIO0_EN: 0,1,0,2,0,1.
- Two DEC of mem[0x03]=0x0002 from req 0 and 2 simultaneously -> final 0x0000, rsp_data 0x0001 then 0x0000, no lost update.
- Assert rst during CAPTURE of a DEC -> no ack, busy=0 and all outputs 0 next cycle, memory unchanged.
